// File: rtl/sm_conv_pipe.sv
// sm_conv_pipe: two-stage sign-magnitude to one's/two's-complement lane converter
// with valid/ready flow control and a saturating negative-zero counter.
// Optional build macro: SM_CONV_NEGZERO_NORM_EN (mode-0 negative zero emitted as +0).
module sm_conv_pipe #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic                    in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        negzero_cnt
);
    localparam int DW = LANES * LANE_W;
    localparam int PW = $clog2(LANES + 1);

    function automatic logic signed [LANE_W-1:0] ones_cmp(input logic [LANE_W-1:0] lane);
        return {lane[LANE_W-1], lane[LANE_W-2:0] ^ {(LANE_W-1){lane[LANE_W-1]}}};
    endfunction

    function automatic logic is_negzero(input logic [LANE_W-1:0] lane);
        return lane[LANE_W-1] && (lane[LANE_W-2:0] == '0);
    endfunction

    function automatic logic signed [LANE_W-1:0] add_inc(input logic signed [LANE_W-1:0] t,
                                                         input logic inc);
        return t + $signed({{(LANE_W-1){1'b0}}, inc});
    endfunction

    function automatic logic [PW-1:0] popcnt(input logic [LANES-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int k = 0; k < LANES; k++) n = n + PW'(v[k]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PW-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic                    vld_p1, vld_p2;
    logic [DW-1:0]           t_p0, t_p1;
    logic [LANES-1:0]        inc_p0, inc_p1;
    logic [LANES-1:0]        nz_p0;
    logic [DW-1:0]           sum_p1, data_p2;
    logic [LANE_W-1:0]       lane;
    logic                    acc, s2_en;
    logic [CNT_W-1:0]        cnt_base;

    assign in_ready  = !rst && (!vld_p1 || !vld_p2 || out_ready);
    assign acc       = in_valid && in_ready;
    assign s2_en     = !vld_p2 || out_ready;
    assign out_valid = vld_p2;
    assign out_data  = data_p2;

    // Stage 0 -> 1: sign-conditional inversion of the magnitude, increment flag per lane
    always_comb begin
        lane   = '0;
        t_p0   = '0;
        inc_p0 = '0;
        nz_p0  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane                     = in_data[k*LANE_W +: LANE_W];
            t_p0[k*LANE_W +: LANE_W] = ones_cmp(lane);
            inc_p0[k]                = lane[LANE_W-1] & in_mode;
            nz_p0[k]                 = is_negzero(lane);
`ifdef SM_CONV_NEGZERO_NORM_EN
            if (nz_p0[k] && !in_mode) t_p0[k*LANE_W +: LANE_W] = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            t_p1   <= t_p0;
            inc_p1 <= inc_p0;
        end
    end

    // Stage 1 -> 2: per-lane increment, carries never cross lane boundaries
    always_comb begin
        sum_p1 = '0;
        for (int k = 0; k < LANES; k++)
            sum_p1[k*LANE_W +: LANE_W] = add_inc(t_p1[k*LANE_W +: LANE_W], inc_p1[k]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            data_p2 <= '0;
        else if (s2_en && vld_p1)
            data_p2 <= sum_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (acc)
                vld_p1 <= 1'b1;
            else if (s2_en)
                vld_p1 <= 1'b0;
            if (s2_en)
                vld_p2 <= vld_p1;
        end
    end

    // Clear acts before the add so a clear+accept cycle loads that beat's count
    assign cnt_base = cnt_clr ? '0 : negzero_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            negzero_cnt <= '0;
        else if (acc)
            negzero_cnt <= sat_add(cnt_base, popcnt(nz_p0));
        else if (cnt_clr)
            negzero_cnt <= '0;
    end
endmodule

// File: tb/tb_sm_conv_pipe.sv
// Testbench for sm_conv_pipe: randomized and directed beats against a sign-magnitude
// arithmetic reference model; a second instance with CNT_W=4 covers counter saturation.
module tb_sm_conv_pipe;
    localparam int LW = 8;
    localparam int NL = 4;
    localparam int DW = LW * NL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_mode, out_ready, cnt_clr;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [15:0]   negzero_cnt;

    logic          s_rst, s_in_valid, s_in_mode, s_out_ready, s_cnt_clr;
    logic [DW-1:0] s_in_data;
    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_cnt;

    sm_conv_pipe #(.LANE_W(LW), .LANES(NL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .cnt_clr(cnt_clr),
        .negzero_cnt(negzero_cnt)
    );

    sm_conv_pipe #(.LANE_W(LW), .LANES(NL), .CNT_W(4)) dut_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_mode(s_in_mode), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .cnt_clr(s_cnt_clr),
        .negzero_cnt(s_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_m   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    // Reference: interpret each lane as a sign-magnitude number and emit its
    // one's- or two's-complement encoding modulo 256.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic m);
        logic [DW-1:0] r;
        int mag, s, v;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            mag = int'(d[k*LW +: 7]);
            s   = int'(d[k*LW + 7]);
            if (s == 0)  v = mag;
            else if (m)  v = (256 - mag) % 256;
            else         v = 255 - mag;
`ifdef SM_CONV_NEGZERO_NORM_EN
            if (s == 1 && !m && mag == 0) v = 0;
`endif
            r[k*LW +: LW] = v[7:0];
        end
        return r;
    endfunction

    function automatic int nz(input logic [DW-1:0] d);
        int n;
        n = 0;
        for (int k = 0; k < NL; k++) if (d[k*LW +: LW] == 8'h80) n++;
        return n;
    endfunction

    // One clock with inputs already set at the falling edge; updates the model.
    task automatic cyc(output bit acc);
        #1;
        acc = in_valid && in_ready && !rst;
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (!rst) begin
            if (cnt_clr) cnt_m = 0;
            if (acc) begin
                exp_q.push_back(model(in_data, in_mode));
                cnt_m = cnt_m + nz(in_data);
                if (cnt_m > 65535) cnt_m = 65535;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit a;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        for (int i = 0; i < 5; i++) cyc(a);
    endtask

    task automatic test_reset();
        bit a;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        cyc(a);
        cyc(a);
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || negzero_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b out_data=%h cnt=%0d want 0/0/0",
                     out_valid, out_data, negzero_cnt);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
        end
        exp_q.delete(); got_q.delete(); cnt_m = 0;
    endtask

    task automatic test_mode0();
        bit a;
        logic [DW-1:0] want;
`ifdef SM_CONV_NEGZERO_NORM_EN
        want = 32'hFA7F0000;
`else
        want = 32'hFA7FFF00;
`endif
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_data = 32'h857F8000;
        cyc(a);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mode0_latency_early: out_valid=%b want 0", out_valid);
        end
        cyc(a);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== want) begin
            n_fail++;
            $display("FAIL mode0_latency2: out_valid=%b out_data=%h want 1/%h", out_valid, out_data, want);
        end
        in_valid = 1'b1; in_data = 32'h0000_0000;
        cyc(a);
        drain();
        n_tests++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++; $display("FAIL mode0_count: got %0d beats want 2", got_q.size());
        end else begin
            n_tests++;
            if (got_q[1] !== 32'h0) begin
                n_fail++; $display("FAIL mode0_zero: got %h want 00000000", got_q[1]);
            end
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL mode0_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_mode1();
        bit a;
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b1;
        in_data = 32'h857F8000;
        cyc(a);
        in_data = 32'h81FF0102;
        cyc(a);
        drain();
        n_tests++;
        if (got_q.size() != 2) begin
            n_fail++; $display("FAIL mode1_count: got %0d beats want 2", got_q.size());
        end else begin
            n_tests++;
            if (got_q[0] !== 32'hFB7F0000) begin
                n_fail++; $display("FAIL mode1_lane_wrap: got %h want FB7F0000", got_q[0]);
            end
            n_tests++;
            if (got_q[1] !== 32'hFF810102) begin
                n_fail++; $display("FAIL mode1_mixed: got %h want FF810102", got_q[1]);
            end
        end
        in_mode = 1'b0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_counter();
        bit a;
        out_ready = 1'b1; in_valid = 1'b0; cnt_clr = 1'b1;
        cyc(a);
        cnt_clr = 1'b0;
        #1;
        n_tests++;
        if (negzero_cnt !== 16'd0) begin
            n_fail++; $display("FAIL cnt_clear_alone: got %0d want 0", negzero_cnt);
        end
        in_valid = 1'b1; in_data = 32'h857F8000;
        cyc(a);
        #1;
        n_tests++;
        if (negzero_cnt !== 16'd1) begin
            n_fail++; $display("FAIL cnt_first: got %0d want 1", negzero_cnt);
        end
        in_data = 32'h80808080;
        cyc(a);
        #1;
        n_tests++;
        if (negzero_cnt !== 16'd5) begin
            n_fail++; $display("FAIL cnt_second: got %0d want 5", negzero_cnt);
        end
        cnt_clr = 1'b1; in_data = 32'h80800000;
        cyc(a);
        cnt_clr = 1'b0;
        #1;
        n_tests++;
        if (negzero_cnt !== 16'd2) begin
            n_fail++; $display("FAIL cnt_clr_with_accept: got %0d want 2", negzero_cnt);
        end
        drain();
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        bit a;
        int i;
        logic [DW-1:0] b[5];
        logic          bm[5];
        logic [DW-1:0] held;
        for (int j = 0; j < 5; j++) begin
            b[j]  = $urandom;
            b[j][15:8] = 8'h80;
            bm[j] = 1'($urandom_range(0, 1));
        end
        i = 0; held = '0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = b[i]; in_mode = bm[i];
            cyc(a);
            if (a) i++;
            #1;
            if (c == 1) held = out_data;
            if (c >= 2) begin
                n_tests++;
                if (out_data !== held || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold: out_data=%h out_valid=%b want %h/1", out_data, out_valid, held);
                end
            end
        end
        n_tests++;
        if (i != 2 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_accepted: accepted=%0d in_ready=%b want 2/0", i, in_ready);
        end
        n_tests++;
        if (negzero_cnt !== 16'(cnt_m)) begin
            n_fail++; $display("FAIL bp_cnt_blocked: got %0d want %0d", negzero_cnt, cnt_m);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && i < 5; c++) begin
            in_data = b[i]; in_mode = bm[i];
            cyc(a);
            if (a) i++;
        end
        drain();
        n_tests++;
        if (i != 5 || got_q.size() != 5) begin
            n_fail++; $display("FAIL bp_release: accepted=%0d emitted=%0d want 5/5", i, got_q.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                n_tests++;
                if (got_q[j] !== model(b[j], bm[j])) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got %h want %h", j, got_q[j], model(b[j], bm[j]));
                end
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        bit a;
        int errs;
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            in_mode   = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            for (int k = 0; k < NL; k++)
                if ($urandom_range(0, 3) == 0) in_data[k*LW +: LW] = 8'h80;
            cyc(a);
            #1;
            n_tests++;
            if (negzero_cnt !== 16'(cnt_m)) begin
                n_fail++;
                if (errs++ < 5) $display("FAIL rand_cnt: got %0d want %0d", negzero_cnt, cnt_m);
            end
        end
        drain();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: emitted %0d accepted %0d", got_q.size(), exp_q.size());
        end else begin
            for (int j = 0; j < got_q.size(); j++) begin
                n_tests++;
                if (got_q[j] !== exp_q[j]) begin
                    n_fail++;
                    if (errs++ < 10) $display("FAIL rand_data[%0d]: got %h want %h", j, got_q[j], exp_q[j]);
                end
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_saturation();
        int want;
        s_rst = 1'b1; s_in_valid = 1'b0; s_in_mode = 1'b0; s_out_ready = 1'b1;
        s_cnt_clr = 1'b0; s_in_data = 32'h80808080;
        @(posedge clk); @(negedge clk);
        s_rst = 1'b0; s_in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_tests++;
            if (s_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL sat_ready[%0d]: got %b want 1", j, s_in_ready);
            end
            @(posedge clk); @(negedge clk);
            want = (4 * (j + 1) > 15) ? 15 : 4 * (j + 1);
            #1;
            n_tests++;
            if (s_cnt !== 4'(want)) begin
                n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", j, s_cnt, want);
            end
        end
        s_in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        n_tests++;
        if (s_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold: got %0d want 15", s_cnt);
        end
        s_cnt_clr = 1'b1; s_in_valid = 1'b1; s_in_data = 32'h80800000;
        @(posedge clk); @(negedge clk);
        s_cnt_clr = 1'b0; s_in_valid = 1'b0;
        #1;
        n_tests++;
        if (s_cnt !== 4'd2) begin
            n_fail++; $display("FAIL sat_clr_accept: got %0d want 2", s_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = 32'h80808080;
        cyc(a);
        in_data = $urandom;
        cyc(a);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || negzero_cnt == 16'd0) begin
            n_fail++;
            $display("FAIL rmid_full: out_valid=%b in_ready=%b cnt=%0d want 1/0/nonzero",
                     out_valid, in_ready, negzero_cnt);
        end
        rst = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ready_in_rst: got %b want 0", in_ready);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || negzero_cnt !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_after: out_valid=%b cnt=%0d in_ready=%b want 0/0/1",
                     out_valid, negzero_cnt, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rmid_ghost[%0d]: out_valid=%b want 0", c, out_valid);
            end
        end
        exp_q.delete(); got_q.delete(); cnt_m = 0;
    endtask

    initial begin
        s_rst = 1'b1; s_in_valid = 1'b0; s_in_mode = 1'b0; s_out_ready = 1'b1;
        s_cnt_clr = 1'b0; s_in_data = '0;
        test_reset();
        test_mode0();
        test_mode1();
        test_counter();
        test_backpressure();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
